// File: rtl/mem_arbiter.sv
// Two-port physical memory arbiter between I-cache and D-cache line traffic.
// Round-robin on ties, one transaction at a time, one-cycle release gap.
module mem_arbiter #(
   parameter int line_size  = 128,
   parameter int addr_width = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_pmem_read,
   input  logic [addr_width-1:0] i_pmem_address,
   output logic [line_size-1:0]  i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [addr_width-1:0] d_pmem_address,
   input  logic [line_size-1:0]  d_pmem_wdata,
   output logic [line_size-1:0]  d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [addr_width-1:0] pmem_address,
   output logic [line_size-1:0]  pmem_wdata,
   input  logic [line_size-1:0]  pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RELEASE
   } state_t;

   state_t state;
   state_t state_next;
   logic   last_d;
   logic   grant_i;
   logic   grant_d;
   logic   d_req;

   assign d_req = d_pmem_read | d_pmem_write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the port that lost the previous grant wins.
            if (i_pmem_read && d_req) begin
               grant_i = last_d;
               grant_d = ~last_d;
            end else begin
               grant_i = i_pmem_read;
               grant_d = d_req;
            end
            if (grant_i) begin
               state_next = SERVE_I;
            end else if (grant_d) begin
               state_next = SERVE_D;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               i_pmem_resp = i_pmem_read;
               state_next  = RELEASE;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               d_pmem_resp = d_req;
               state_next  = RELEASE;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
   assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

   // Payload is captured only at grant so requester changes cannot leak in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_d       <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else if (grant_i) begin
         last_d       <= 1'b0;
         pmem_read    <= 1'b1;
         pmem_write   <= 1'b0;
         pmem_address <= i_pmem_address;
         pmem_wdata   <= '0;
      end else if (grant_d) begin
         last_d       <= 1'b1;
         pmem_read    <= ~d_pmem_write;
         pmem_write   <= d_pmem_write;
         pmem_address <= d_pmem_address;
         pmem_wdata   <= d_pmem_wdata;
      end else if (state_next == RELEASE) begin
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model
// of round-robin grants, captured payloads and response routing.
module tb_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_pmem_read;
   logic [15:0]  i_pmem_address;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [15:0]  d_pmem_address;
   logic [127:0] d_pmem_wdata;
   logic [127:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int checks   = 0;
   int failures = 0;

   // Model state: pending requests and who won the last grant.
   bit           pi, pd, dwr, drd, last_d;
   logic [15:0]  ia, da;
   logic [127:0] dwd;
   bit           grants[$];

   mem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic apply();
      i_pmem_read    = pi;
      i_pmem_address = ia;
      d_pmem_read    = pd && drd;
      d_pmem_write   = pd && dwr;
      d_pmem_address = da;
      d_pmem_wdata   = dwd;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rd"}, pmem_read, 1'b0);
      check({tag, "_wr"}, pmem_write, 1'b0);
      check({tag, "_iresp"}, i_pmem_resp, 1'b0);
      check({tag, "_dresp"}, d_pmem_resp, 1'b0);
      check({tag, "_irdata"}, i_pmem_rdata, 128'h0);
      check({tag, "_drdata"}, d_pmem_rdata, 128'h0);
   endtask

   task automatic new_d(input int op);
      pd  = 1'b1;
      da  = 16'($urandom);
      dwd = rnd128();
      dwr = (op != 0);
      drd = (op != 1);
   endtask

   // Called at a negedge with the DUT in IDLE and at least one request pending.
   task automatic serve(input int lat, input bit drop);
      bit           win_d, live;
      logic [15:0]  ea;
      logic [127:0] ew, rd;
      bit           ewr;
      win_d = pd && (!pi || !last_d);
      last_d = win_d;
      grants.push_back(win_d);
      ea  = win_d ? da : ia;
      ew  = win_d ? dwd : 128'h0;
      ewr = win_d && dwr;
      live = 1'b1;
      apply();
      pmem_resp = 1'($urandom);
      #1 check_quiet("idle");
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      check("grant_addr", pmem_address, ea);
      check("grant_wdata", pmem_wdata, ew);
      check("grant_rd", pmem_read, !ewr);
      check("grant_wr", pmem_write, ewr);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         if (win_d) begin
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = rnd128();
         end else begin
            i_pmem_address = 16'($urandom);
         end
         if (drop && k == 0) begin
            live = 1'b0;
            if (win_d) begin
               d_pmem_read  = 1'b0;
               d_pmem_write = 1'b0;
            end else begin
               i_pmem_read = 1'b0;
            end
         end
         #1;
         check("hold_addr", pmem_address, ea);
         check("hold_wdata", pmem_wdata, ew);
         check("hold_rd", pmem_read, !ewr);
         check("hold_wr", pmem_write, ewr);
         check("hold_iresp", i_pmem_resp, 1'b0);
         check("hold_dresp", d_pmem_resp, 1'b0);
      end
      @(negedge clk);
      rd = rnd128();
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      check("resp_i", i_pmem_resp, !win_d && live);
      check("resp_d", d_pmem_resp, win_d && live);
      check("rdata_i", i_pmem_rdata, (!win_d && live) ? rd : 128'h0);
      check("rdata_d", d_pmem_rdata, (win_d && live) ? rd : 128'h0);
      @(negedge clk);
      if (win_d) pd = 1'b0;
      else pi = 1'b0;
      apply();
      pmem_resp = 1'($urandom);
      #1 check_quiet("release");
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1 check_quiet("rst");
      check("rst_addr", pmem_address, 16'h0);
      check("rst_wdata", pmem_wdata, 128'h0);
      pi = 0; pd = 0; last_d = 0;
      apply();
      pmem_resp = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pi = 0; pd = 0; dwr = 0; drd = 0; last_d = 0;
      ia = 0; da = 0; dwd = 0;
      apply();
      pmem_rdata = 0;
      pmem_resp  = 0;
      @(negedge clk);
      do_reset();

      // I read 0x1200 alone, response 3 cycles later.
      pi = 1; ia = 16'h1200;
      serve(3, 0);
      // Simultaneous I read and D write after reset: D first.
      do_reset();
      pi = 1; ia = 16'h1200;
      pd = 1; da = 16'h4A60; dwr = 1; drd = 0;
      dwd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      serve(2, 0);
      serve(1, 0);
      check("tie_first", grants[grants.size()-2], 1'b1);
      check("tie_second", grants[grants.size()-1], 1'b0);
      // Continuous contention: D,I,D,I,D,I.
      do_reset();
      grants.delete();
      for (int n = 0; n < 6; n++) begin
         pi = 1; ia = 16'($urandom);
         if (!pd) new_d(2);
         serve(n % 3, 0);
      end
      for (int n = 0; n < 6; n++)
         check("alt_order", grants[n], (n % 2) == 0);
      pi = 0;
      if (pd) serve(0, 0);
      // D write-back then D read of 0x0080.
      new_d(1); da = 16'h0080;
      serve(1, 0);
      new_d(0); da = 16'h0080;
      serve(2, 0);
      // Reset in the middle of a D transaction, stray response afterwards.
      new_d(1);
      apply();
      @(negedge clk);
      #1 check("pre_rst_wr", pmem_write, 1'b1);
      reset = 1'b1;
      #1 check_quiet("mid_rst");
      check("mid_rst_addr", pmem_address, 16'h0);
      check("mid_rst_wdata", pmem_wdata, 128'h0);
      pd = 0; last_d = 0;
      apply();
      @(negedge clk);
      reset = 1'b0;
      pmem_resp = 1'b1;
      pmem_rdata = rnd128();
      #1 check_quiet("post_rst");
      @(negedge clk);
      #1 check_quiet("post_rst2");
      pmem_resp = 1'b0;

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         if (!pi && $urandom_range(1, 0) == 1) begin
            pi = 1; ia = 16'($urandom);
         end
         if (!pd && $urandom_range(1, 0) == 1) new_d($urandom_range(2, 0));
         if (pi || pd) begin
            serve($urandom_range(4, 0), $urandom_range(5, 0) == 0);
         end else begin
            apply();
            pmem_resp = 1'($urandom);
            @(negedge clk);
            #1 check_quiet("no_req");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
